ov5640_ddr_wr_arb: RTL and testbench
====================================

Name: ov5640_ddr_wr_arb

Overview:
Two-requester arbiter that shares one AXI datamover write path (command channel plus stream data channel) between two camera write controllers, for example a dual-OV5640 build. Each requester issues one command followed by one data burst terminated by last. The arbiter grants round-robin, forwards the winner's command, then locks the data mux to the winner until the burst's last beat is accepted. It sits between the per-camera DDR write controllers and the datamover S2MM interface.

Parameters:
DATA_W, 128, stream data width in bits (16-byte beats)
ADDR_W, 32, command address width
LEN_W, 32, command byte-length width

Ports:
axi_clk  in  1  single clock for all logic
axi_rst_n  in  1  reset: synchronous, active-low
s0_cmd_addr  in  ADDR_W  requester 0 command address
s0_cmd_len  in  LEN_W  requester 0 command byte length
s0_cmd_valid  in  1  requester 0 command valid
s0_cmd_ready  out  1  requester 0 command accepted
s0_data  in  DATA_W  requester 0 stream data
s0_data_valid  in  1  requester 0 data valid
s0_data_last  in  1  requester 0 last beat
s0_data_ready  out  1  requester 0 data ready
s1_cmd_addr, s1_cmd_len, s1_cmd_valid, s1_cmd_ready, s1_data, s1_data_valid, s1_data_last, s1_data_ready: same as s0_*, for requester 1
m_cmd_addr  out  ADDR_W  to datamover
m_cmd_len  out  LEN_W  to datamover
m_cmd_valid  out  1  to datamover
m_cmd_ready  in  1  from datamover
m_data  out  DATA_W  to datamover
m_data_valid  out  1  to datamover
m_data_last  out  1  to datamover
m_data_ready  in  1  from datamover
grant  out  2  one-hot owner; 00 when idle
busy  out  1  high in CMD or DATA state

Behaviour:
- States (one-hot, 3 bits): IDLE=001, CMD=010, DATA=100. Any illegal encoding goes to IDLE next cycle.
- Reset (axi_rst_n=0 at an edge), including mid-burst: state IDLE, grant=00, prio=0, m_cmd_valid=0, m_cmd_addr/len=0, all s*_cmd_ready=0. Data outputs read as 0/invalid because grant=00. No partial burst is resumed.
- IDLE:
  - If any sN_cmd_valid is high, pick the winner: if both are high, requester prio wins; otherwise the single one wins.
  - On the same edge: capture the winner's addr/len into m_cmd_addr/len, set grant one-hot, assert m_cmd_valid, pulse the winner's sN_cmd_ready for exactly that cycle (combinational ready in IDLE for the winner only), and go to CMD.
  - Latency from sN_cmd_valid to m_cmd_valid is 1 cycle.
- CMD: hold m_cmd_valid and the captured fields stable until m_cmd_valid & m_cmd_ready, then deassert m_cmd_valid and go to DATA.
- DATA:
  - Combinational mux: m_data/m_data_valid/m_data_last come from the granted requester, and that requester's sN_data_ready = m_data_ready.
  - The loser's data_ready stays 0.
  - On m_data_valid & m_data_ready & m_data_last: go to IDLE, grant=00, and prio becomes the other requester (the requester just served gets lowest priority).
- A data beat on the non-granted requester is never forwarded or accepted. sN_data_ready=0 in IDLE and CMD.
- busy = state != IDLE.
- Simultaneous valids from both requesters in IDLE: only one is accepted. The other keeps valid high and wins the next arbitration.
- Single-beat burst (valid & last on the first beat) is legal and returns to IDLE on that beat.
- The arbiter is 0 cycles on the data path and adds no buffering.

Optional Feature:
- Macro ARB_STAT_EN.
- Defined: add outputs stat_burst0, stat_burst1 (32 bits each), counting completed bursts per requester. Each increments on the accepted last beat of that requester's burst, wraps at 2^32, and clears on reset.
- Also add stat_stall (32 bits), counting cycles with m_data_valid=1 and m_data_ready=0 in DATA.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package ov5640_ddr_pkg: state encoding localparams IDLE/CMD/DATA, DATA_W/ADDR_W/LEN_W defaults.
- One sub-module: ov5640_rr_pick2. It is combinational: inputs req[1:0] and prio, output one-hot win[1:0]. Instantiated once.
- The mux, FSM and stats stay in the top.

Test Plan:
- Reset, then s0_cmd_valid with addr=0x1000_0000 and len=0x1000 → next cycle m_cmd_valid=1 with those values and grant=01. With m_cmd_ready held 1, 4 beats with last on beat 4 → all forwarded, state IDLE, prio=1.
- Both cmd_valid high from reset → s0 granted first. After its last beat, s1 granted (addr 0x2000_0000). Then s0 again.
- m_cmd_ready held 0 for 10 cycles → m_cmd_valid and addr/len stay stable, and no data_ready is asserted.
- During an s0 burst, toggle s1_data_valid → s1_data_ready stays 0 and m_data always equals s0_data. Backpressure m_data_ready 1/0 alternately → beat count is preserved.
- Assert axi_rst_n=0 for 1 cycle mid-burst on beat 2 of 8 → grant=00 and m_cmd_valid=0 the next cycle. A new s1 command is then granted normally.
- With ARB_STAT_EN: 3 bursts from s0 and 2 from s1 → stat_burst0=3, stat_burst1=2. stat_stall equals the number of injected m_data_ready=0 cycles.

Source files
------------

// File: rtl/ov5640_ddr_pkg.sv
// Shared constants for the dual-camera datamover write arbiter: FSM encoding and width defaults.
package ov5640_ddr_pkg;

   localparam int DEF_DATA_W = 128;
   localparam int DEF_ADDR_W = 32;
   localparam int DEF_LEN_W  = 32;

   localparam logic [2:0] IDLE = 3'b001;
   localparam logic [2:0] CMD  = 3'b010;
   localparam logic [2:0] DATA = 3'b100;

   // The requester just served drops to lowest priority.
   function automatic logic next_prio(input logic [1:0] served);
      return served[0];
   endfunction

endpackage

// File: rtl/ov5640_rr_pick2.sv
// Two-way round-robin pick: one-hot winner from the request vector and the current priority holder.
module ov5640_rr_pick2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] win
);

   always_comb begin
      win = 2'b00;
      case (req)
         2'b01:   win = 2'b01;
         2'b10:   win = 2'b10;
         2'b11:   win = prio ? 2'b10 : 2'b01;
         default: win = 2'b00;
      endcase
   end

endmodule

// File: rtl/ov5640_ddr_wr_arb.sv
// Shares one datamover S2MM command/stream path between two camera write controllers.
// Define ARB_STAT_EN to add per-requester burst counters and a data stall counter.
module ov5640_ddr_wr_arb
   import ov5640_ddr_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic              axi_clk,
   input  logic              axi_rst_n,

   input  logic [ADDR_W-1:0] s0_cmd_addr,
   input  logic [LEN_W-1:0]  s0_cmd_len,
   input  logic              s0_cmd_valid,
   output logic              s0_cmd_ready,
   input  logic [DATA_W-1:0] s0_data,
   input  logic              s0_data_valid,
   input  logic              s0_data_last,
   output logic              s0_data_ready,

   input  logic [ADDR_W-1:0] s1_cmd_addr,
   input  logic [LEN_W-1:0]  s1_cmd_len,
   input  logic              s1_cmd_valid,
   output logic              s1_cmd_ready,
   input  logic [DATA_W-1:0] s1_data,
   input  logic              s1_data_valid,
   input  logic              s1_data_last,
   output logic              s1_data_ready,

   output logic [ADDR_W-1:0] m_cmd_addr,
   output logic [LEN_W-1:0]  m_cmd_len,
   output logic              m_cmd_valid,
   input  logic              m_cmd_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_data_valid,
   output logic              m_data_last,
   input  logic              m_data_ready,

`ifdef ARB_STAT_EN
   output logic [31:0]       stat_burst0,
   output logic [31:0]       stat_burst1,
   output logic [31:0]       stat_stall,
`endif
   output logic [1:0]        grant,
   output logic              busy
);

   logic [2:0]        state_q, state_d;
   logic [1:0]        grant_q, grant_d;
   logic              prio_q, prio_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [LEN_W-1:0]  cmd_len_q, cmd_len_d;

   logic [1:0] req;
   logic [1:0] win;
   logic [1:0] cmd_rdy;
   logic [1:0] data_rdy;
   logic       in_idle;
   logic       in_data;
   logic       beat_last;

   assign req     = {s1_cmd_valid, s0_cmd_valid};
   assign in_idle = (state_q == IDLE);
   assign in_data = (state_q == DATA);

   ov5640_rr_pick2 u_pick (
      .req  (req),
      .prio (prio_q),
      .win  (win)
   );

   // Command ready is a single-cycle combinational pulse for the IDLE winner only.
   for (genvar gi = 0; gi < 2; gi++) begin : g_rdy
      assign cmd_rdy[gi]  = in_idle & win[gi];
      assign data_rdy[gi] = in_data & grant_q[gi] & m_data_ready;
   end

   assign s0_cmd_ready  = cmd_rdy[0];
   assign s1_cmd_ready  = cmd_rdy[1];
   assign s0_data_ready = data_rdy[0];
   assign s1_data_ready = data_rdy[1];

   // Zero-latency data mux; anything outside DATA reads as idle.
   always_comb begin
      m_data       = '0;
      m_data_valid = 1'b0;
      m_data_last  = 1'b0;
      if (in_data && grant_q[0]) begin
         m_data       = s0_data;
         m_data_valid = s0_data_valid;
         m_data_last  = s0_data_last;
      end else if (in_data && grant_q[1]) begin
         m_data       = s1_data;
         m_data_valid = s1_data_valid;
         m_data_last  = s1_data_last;
      end
   end

   assign beat_last = m_data_valid & m_data_ready & m_data_last;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      prio_d      = prio_q;
      cmd_valid_d = cmd_valid_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_len_d   = cmd_len_q;
      case (state_q)
         IDLE: begin
            if (|win) begin
               cmd_addr_d  = win[1] ? s1_cmd_addr : s0_cmd_addr;
               cmd_len_d   = win[1] ? s1_cmd_len  : s0_cmd_len;
               grant_d     = win;
               cmd_valid_d = 1'b1;
               state_d     = CMD;
            end
         end
         CMD: begin
            if (cmd_valid_q && m_cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = DATA;
            end
         end
         DATA: begin
            if (beat_last) begin
               grant_d = 2'b00;
               prio_d  = next_prio(grant_q);
               state_d = IDLE;
            end
         end
         default: begin
            grant_d     = 2'b00;
            cmd_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (!axi_rst_n) begin
         state_q     <= IDLE;
         grant_q     <= 2'b00;
         prio_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_len_q   <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         prio_q      <= prio_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_len_q   <= cmd_len_d;
      end
   end

   assign m_cmd_addr  = cmd_addr_q;
   assign m_cmd_len   = cmd_len_q;
   assign m_cmd_valid = cmd_valid_q;
   assign grant       = grant_q;
   assign busy        = ~in_idle;

`ifdef ARB_STAT_EN
   logic [31:0] stat_b0_q;
   logic [31:0] stat_b1_q;
   logic [31:0] stat_stall_q;

   always_ff @(posedge axi_clk) begin
      if (!axi_rst_n) begin
         stat_b0_q    <= '0;
         stat_b1_q    <= '0;
         stat_stall_q <= '0;
      end else begin
         if (beat_last && grant_q[0]) stat_b0_q <= stat_b0_q + 32'd1;
         if (beat_last && grant_q[1]) stat_b1_q <= stat_b1_q + 32'd1;
         if (in_data && m_data_valid && !m_data_ready) stat_stall_q <= stat_stall_q + 32'd1;
      end
   end

   assign stat_burst0 = stat_b0_q;
   assign stat_burst1 = stat_b1_q;
   assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_ov5640_ddr_wr_arb.sv
// Directed bench for ov5640_ddr_wr_arb; stat counters are checked when ARB_STAT_EN is defined.
module tb_ov5640_ddr_wr_arb;

   logic         axi_clk = 1'b0;
   logic         axi_rst_n;
   logic [31:0]  s0_cmd_addr, s1_cmd_addr, s0_cmd_len, s1_cmd_len;
   logic         s0_cmd_valid, s1_cmd_valid, s0_cmd_ready, s1_cmd_ready;
   logic [127:0] s0_data, s1_data;
   logic         s0_data_valid, s0_data_last, s0_data_ready;
   logic         s1_data_valid, s1_data_last, s1_data_ready;
   logic [31:0]  m_cmd_addr, m_cmd_len;
   logic         m_cmd_valid, m_cmd_ready;
   logic [127:0] m_data;
   logic         m_data_valid, m_data_last, m_data_ready;
   logic [1:0]   grant;
   logic         busy;
`ifdef ARB_STAT_EN
   logic [31:0]  stat_burst0, stat_burst1, stat_stall;
`endif

   int checks   = 0;
   int failures = 0;
   int exp_b0   = 0;
   int exp_b1   = 0;
   int exp_stall = 0;

   always #5 axi_clk = ~axi_clk;

   ov5640_ddr_wr_arb dut (
      .axi_clk       (axi_clk),
      .axi_rst_n     (axi_rst_n),
      .s0_cmd_addr   (s0_cmd_addr),
      .s0_cmd_len    (s0_cmd_len),
      .s0_cmd_valid  (s0_cmd_valid),
      .s0_cmd_ready  (s0_cmd_ready),
      .s0_data       (s0_data),
      .s0_data_valid (s0_data_valid),
      .s0_data_last  (s0_data_last),
      .s0_data_ready (s0_data_ready),
      .s1_cmd_addr   (s1_cmd_addr),
      .s1_cmd_len    (s1_cmd_len),
      .s1_cmd_valid  (s1_cmd_valid),
      .s1_cmd_ready  (s1_cmd_ready),
      .s1_data       (s1_data),
      .s1_data_valid (s1_data_valid),
      .s1_data_last  (s1_data_last),
      .s1_data_ready (s1_data_ready),
      .m_cmd_addr    (m_cmd_addr),
      .m_cmd_len     (m_cmd_len),
      .m_cmd_valid   (m_cmd_valid),
      .m_cmd_ready   (m_cmd_ready),
      .m_data        (m_data),
      .m_data_valid  (m_data_valid),
      .m_data_last   (m_data_last),
      .m_data_ready  (m_data_ready),
`ifdef ARB_STAT_EN
      .stat_burst0   (stat_burst0),
      .stat_burst1   (stat_burst1),
      .stat_stall    (stat_stall),
`endif
      .grant         (grant),
      .busy          (busy)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge axi_clk);
      #1;
   endtask

   // Issue one command; m_cmd_ready is held low for 'hold' cycles while data readiness is probed.
   task automatic send_cmd(input bit who, input logic [31:0] a, input logic [31:0] l, input int hold);
      if (who) begin s1_cmd_addr = a; s1_cmd_len = l; s1_cmd_valid = 1'b1; end
      else     begin s0_cmd_addr = a; s0_cmd_len = l; s0_cmd_valid = 1'b1; end
      #1;
      check("cmd_ready_win", who ? s1_cmd_ready : s0_cmd_ready, 1'b1);
      check("cmd_ready_lose", who ? s0_cmd_ready : s1_cmd_ready, 1'b0);
      cyc();
      s0_cmd_valid = 1'b0;
      s1_cmd_valid = 1'b0;
      check("m_cmd_valid", m_cmd_valid, 1'b1);
      check("m_cmd_addr", m_cmd_addr, a);
      check("m_cmd_len", m_cmd_len, l);
      check("grant_cmd", grant, who ? 2'b10 : 2'b01);
      check("busy_cmd", busy, 1'b1);
      for (int i = 0; i < hold; i++) begin
         s0_data_valid = 1'b1;
         s1_data_valid = 1'b1;
         m_data_ready  = 1'b1;
         #1;
         check("hold_valid", m_cmd_valid, 1'b1);
         check("hold_addr", m_cmd_addr, a);
         check("hold_len", m_cmd_len, l);
         check("hold_rdy", {s1_data_ready, s0_data_ready}, 2'b00);
         check("hold_mvalid", m_data_valid, 1'b0);
         cyc();
      end
      s0_data_valid = 1'b0;
      s1_data_valid = 1'b0;
      m_data_ready  = 1'b0;
      m_cmd_ready   = 1'b1;
      cyc();
      m_cmd_ready = 1'b0;
      check("cmd_drop", m_cmd_valid, 1'b0);
      check("busy_data", busy, 1'b1);
   endtask

   // Stream n beats from 'who' while the other side toggles junk; stall alternates m_data_ready.
   task automatic send_beats(input bit who, input int n, input bit stall);
      int acc;
      int k;
      logic [127:0] d;
      logic rdy;
      acc = 0;
      k   = 0;
      while (acc < n && k < 4 * n + 8) begin
         d   = {$urandom, $urandom, $urandom, $urandom};
         rdy = stall ? (k % 2 == 1) : 1'b1;
         m_data_ready = rdy;
         if (who) begin
            s1_data = d; s1_data_valid = 1'b1; s1_data_last = (acc == n - 1);
            s0_data = ~d; s0_data_valid = (k % 2 == 0); s0_data_last = 1'b1;
         end else begin
            s0_data = d; s0_data_valid = 1'b1; s0_data_last = (acc == n - 1);
            s1_data = ~d; s1_data_valid = (k % 2 == 0); s1_data_last = 1'b1;
         end
         #1;
         check("m_data", m_data, d);
         check("m_data_valid", m_data_valid, 1'b1);
         check("m_data_last", m_data_last, acc == n - 1);
         check("rdy_owner", who ? s1_data_ready : s0_data_ready, rdy);
         check("rdy_loser", who ? s0_data_ready : s1_data_ready, 1'b0);
         if (!rdy) exp_stall++;
         if (rdy) begin
            acc++;
            if (acc == n) begin
               if (who) exp_b1++;
               else     exp_b0++;
            end
         end
         cyc();
         k++;
      end
      s0_data_valid = 1'b0; s0_data_last = 1'b0;
      s1_data_valid = 1'b0; s1_data_last = 1'b0;
      m_data_ready  = 1'b0;
      check("beat_count", acc, n);
      check("grant_idle", grant, 2'b00);
      check("busy_idle", busy, 1'b0);
   endtask

   task automatic pulse_reset();
      axi_rst_n = 1'b0;
      cyc();
      axi_rst_n = 1'b1;
      exp_b0 = 0; exp_b1 = 0; exp_stall = 0;
   endtask

   initial begin
      axi_rst_n = 1'b0;
      s0_cmd_addr = '0; s0_cmd_len = '0; s0_cmd_valid = 1'b0;
      s1_cmd_addr = '0; s1_cmd_len = '0; s1_cmd_valid = 1'b0;
      s0_data = '0; s0_data_valid = 1'b0; s0_data_last = 1'b0;
      s1_data = '0; s1_data_valid = 1'b0; s1_data_last = 1'b0;
      m_cmd_ready = 1'b0; m_data_ready = 1'b0;
      cyc(); cyc();
      check("rst_grant", grant, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_valid", m_cmd_valid, 1'b0);
      check("rst_cmd_addr", m_cmd_addr, 32'h0);
      check("rst_data_valid", m_data_valid, 1'b0);
      axi_rst_n = 1'b1;
      cyc();

      // Single requester, 4-beat burst.
      send_cmd(1'b0, 32'h1000_0000, 32'h0000_1000, 0);
      send_beats(1'b0, 4, 1'b0);

      // Reset clears prio: simultaneous requests go to s0, then s1, then s0.
      pulse_reset();
      s0_cmd_addr = 32'h1100_0000; s0_cmd_len = 32'h200;
      s1_cmd_addr = 32'h2000_0000; s1_cmd_len = 32'h300;
      s0_cmd_valid = 1'b1; s1_cmd_valid = 1'b1;
      #1;
      check("both_s0_rdy", s0_cmd_ready, 1'b1);
      check("both_s1_rdy", s1_cmd_ready, 1'b0);
      cyc();
      s0_cmd_valid = 1'b0;
      check("both_grant", grant, 2'b01);
      check("both_addr", m_cmd_addr, 32'h1100_0000);
      check("s1_waits", s1_cmd_ready, 1'b0);
      m_cmd_ready = 1'b1;
      cyc();
      m_cmd_ready = 1'b0;
      send_beats(1'b0, 2, 1'b0);
      send_cmd(1'b1, 32'h2000_0000, 32'h300, 0);
      send_beats(1'b1, 3, 1'b0);
      send_cmd(1'b0, 32'h1200_0000, 32'h10, 0);
      send_beats(1'b0, 1, 1'b0);

      // prio now favours s1 after s0 was served.
      s0_cmd_addr = 32'h1300_0000; s0_cmd_len = 32'h20;
      s1_cmd_addr = 32'h2100_0000; s1_cmd_len = 32'h30;
      s0_cmd_valid = 1'b1; s1_cmd_valid = 1'b1;
      #1;
      check("rr_s1_rdy", s1_cmd_ready, 1'b1);
      check("rr_s0_rdy", s0_cmd_ready, 1'b0);
      cyc();
      s1_cmd_valid = 1'b0;
      check("rr_grant", grant, 2'b10);
      check("rr_addr", m_cmd_addr, 32'h2100_0000);
      m_cmd_ready = 1'b1;
      cyc();
      m_cmd_ready = 1'b0;
      send_beats(1'b1, 1, 1'b0);
      send_cmd(1'b0, 32'h1300_0000, 32'h20, 0);
      send_beats(1'b0, 1, 1'b0);

      // Command backpressure for 10 cycles, then a backpressured data burst.
      send_cmd(1'b0, 32'h1400_0000, 32'h60, 10);
      send_beats(1'b0, 6, 1'b1);

      // Reset on beat 2 of 8.
      send_cmd(1'b0, 32'h1500_0000, 32'h80, 0);
      s0_data = 128'h1; s0_data_valid = 1'b1; s0_data_last = 1'b0; m_data_ready = 1'b1;
      cyc();
      s0_data = 128'h2;
      pulse_reset();
      s0_data_valid = 1'b0; m_data_ready = 1'b0;
      check("mid_rst_grant", grant, 2'b00);
      check("mid_rst_cmd_valid", m_cmd_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_addr", m_cmd_addr, 32'h0);
      check("mid_rst_rdy", s0_data_ready, 1'b0);
      send_cmd(1'b1, 32'h3000_0000, 32'h10, 0);
      send_beats(1'b1, 1, 1'b0);

      // Mixed traffic for the burst/stall counters.
      send_cmd(1'b0, 32'h1600_0000, 32'h20, 0);
      send_beats(1'b0, 2, 1'b1);
      send_cmd(1'b0, 32'h1700_0000, 32'h20, 0);
      send_beats(1'b0, 2, 1'b0);
      send_cmd(1'b0, 32'h1800_0000, 32'h30, 0);
      send_beats(1'b0, 3, 1'b1);
      send_cmd(1'b1, 32'h3100_0000, 32'h30, 0);
      send_beats(1'b1, 3, 1'b1);
`ifdef ARB_STAT_EN
      check("stat_burst0", stat_burst0, exp_b0);
      check("stat_burst1", stat_burst1, exp_b1);
      check("stat_stall", stat_stall, exp_stall);
      check("stat_b0_is3", stat_burst0, 32'd3);
      check("stat_b1_is2", stat_burst1, 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
